// File: rtl/memtest_pkg.sv
// Shared types and LFSR math for the SDRAM memory-test sequencer.
// ST_HALT exists only when MEMTEST_ERR_HALT_EN is defined.
package memtest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RWAIT
`ifdef MEMTEST_ERR_HALT_EN
    , ST_HALT
`endif
  } memtest_state_t;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Galois form, shifting right: the bit falling out of bit 0 folds back in through the taps.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/memtest_if.sv
// User-port bundle between the memory-test sequencer (master) and the SDRAM controller (slave).
// Handshake: req/we/addr/wdata hold steady from req rising through the cycle ack is high; a command
// completes only on a cycle with req && ack. rvalid returns one beat per accepted read, in order.
interface memtest_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rvalid, rdata);
endinterface

// File: rtl/memtest_lfsr.sv
// 32-bit pattern generator: load takes priority over advance; holds otherwise.
module memtest_lfsr
  import memtest_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        adv,
  output logic [31:0] state
);
  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load)     lfsr_d = seed;
    else if (adv) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 32'h0;
    else     lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;
endmodule

// File: rtl/memtest_sequencer.sv
// Write pass then read-verify pass over 0..LAST_ADDR with a per-pass LFSR pattern.
// Build option MEMTEST_ERR_HALT_EN: freeze in HALT on the first mismatch.
module memtest_sequencer
  import memtest_pkg::*;
#(
  parameter int                ADDR_W    = 24,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}},
  parameter logic [31:0]       SEED      = 32'hACE1_2024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  memtest_if.master          bus,
  output logic               busy,
  output logic               error,
  output logic [ADDR_W-1:0]  err_addr,
  output logic [7:0]         err_cnt,
  output logic [3:0]         pass_cnt,
  output memtest_state_t     dbg_state
);
  memtest_state_t    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, err_addr_q, err_addr_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [3:0]        pass_cnt_q, pass_cnt_d;
  logic              error_q, error_d, stop_pend_q, stop_pend_d;
  logic              req_q, req_d, we_q, we_d, busy_q, busy_d;
  logic              lfsr_load, lfsr_adv, rd_bad;
  logic [31:0]       lfsr_seed, lfsr_state;

  memtest_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .seed  (lfsr_seed),
    .adv   (lfsr_adv),
    .state (lfsr_state)
  );

  if (DATA_W < 32) begin : g_hi
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr_state[31:DATA_W];
  end

  assign rd_bad = (bus.rdata != lfsr_state[DATA_W-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      err_addr_q  <= '0;
      err_cnt_q   <= '0;
      pass_cnt_q  <= '0;
      error_q     <= 1'b0;
      stop_pend_q <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      err_addr_q  <= err_addr_d;
      err_cnt_q   <= err_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      error_q     <= error_d;
      stop_pend_q <= stop_pend_d;
      req_q       <= req_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    pass_cnt_d = pass_cnt_q;
    lfsr_load  = 1'b0;
    lfsr_adv   = 1'b0;
    lfsr_seed  = SEED ^ {28'b0, pass_cnt_q};
    case (state_q)
      ST_IDLE: if (start) begin
        state_d    = ST_WRITE;
        addr_d     = '0;
        error_d    = 1'b0;
        err_addr_d = '0;
        err_cnt_d  = '0;
        pass_cnt_d = '0;
        lfsr_load  = 1'b1;
        lfsr_seed  = SEED;
      end
      ST_WRITE: if (bus.ack) begin
        if (addr_q == LAST_ADDR) begin
          addr_d    = '0;
          lfsr_load = 1'b1;
          state_d   = ST_READ;
        end else begin
          addr_d   = addr_q + ADDR_W'(1);
          lfsr_adv = 1'b1;
        end
      end
      ST_READ: if (bus.ack) state_d = ST_RWAIT;
      ST_RWAIT: if (bus.rvalid) begin
        if (rd_bad) begin
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          if (!error_q) begin
            error_d    = 1'b1;
            err_addr_d = addr_q;
          end
        end
`ifdef MEMTEST_ERR_HALT_EN
        if (rd_bad && !error_q) state_d = ST_HALT;
        else
`endif
        begin
          lfsr_adv = 1'b1;
          if (addr_q != LAST_ADDR) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_READ;
          end else begin
            pass_cnt_d = pass_cnt_q + 4'd1;
            addr_d     = '0;
            if (stop_pend_q || stop) begin
              state_d = ST_IDLE;
            end else begin
              state_d   = ST_WRITE;
              lfsr_load = 1'b1;
              lfsr_seed = SEED ^ {28'b0, pass_cnt_d};
            end
          end
        end
      end
`ifdef MEMTEST_ERR_HALT_EN
      ST_HALT: if (stop) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
    // A stop only counts once running, and is consumed whenever we fall back to IDLE.
    stop_pend_d = stop_pend_q | (stop & (state_q != ST_IDLE));
    if (state_d == ST_IDLE) stop_pend_d = 1'b0;
  end

  always_comb begin
    req_d  = (state_d == ST_WRITE) || (state_d == ST_READ);
    we_d   = (state_d == ST_WRITE);
    busy_d = (state_d != ST_IDLE);
  end

  assign bus.req   = req_q;
  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = lfsr_state[DATA_W-1:0];
  assign busy      = busy_q;
  assign error     = error_q;
  assign err_addr  = err_addr_q;
  assign err_cnt   = err_cnt_q;
  assign pass_cnt  = pass_cnt_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_memtest_sequencer.sv
// Directed bench for memtest_sequencer over a 16-word range with a behavioural SDRAM port model.
module tb_memtest_sequencer;
  import memtest_pkg::*;

  localparam int          ADDR_W = 24;
  localparam int          DATA_W = 16;
  localparam int          W      = ADDR_W + DATA_W;
  localparam logic [31:0] SEED   = 32'hACE1_2024;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic busy, error;
  logic [ADDR_W-1:0] err_addr;
  logic [7:0]        err_cnt;
  logic [3:0]        pass_cnt;
  memtest_state_t    dbg_state;

  memtest_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  memtest_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADDR(24'd15), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .bus(bus),
    .busy(busy), .error(error), .err_addr(err_addr), .err_cnt(err_cnt),
    .pass_cnt(pass_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic fb;
    fb = s[0];
    s  = {1'b0, s[31:1]};
    if (fb) s = s ^ 32'h8020_0003;
    return s;
  endfunction

  // scoreboard and port model state
  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] wlog[$];
  int                wcyc[$];
  logic [DATA_W-1:0] mem [16];
  int                ack_wait = -1, rv_cnt = 0, rd_last = -1;
  logic [3:0]        rv_addr = '0, rd_next = '0, corrupt_addr = '0;
  bit                ack_hold = 0, corrupt_all = 0, corrupt_en = 0;

  task automatic fill_pass(input logic [3:0] p);
    logic [31:0] s;
    s = SEED ^ {28'b0, p};
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({ADDR_W'(i), s[DATA_W-1:0]});
      s = ref_step(s);
    end
  endtask

  // SDRAM port model: ack after 0-3 cycles (or at once when held), rvalid 2 cycles after a read ack
  initial begin
    logic [W-1:0] e;
    logic         flip;
    bus.ack = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.ack = 1'b0; bus.rvalid = 1'b0;
      if (rst) begin
        ack_wait = -1; rv_cnt = 0;
      end else begin
        if (dbg_state == ST_IDLE) rd_next = '0;
        if (rv_cnt > 0) begin
          rv_cnt--;
          if (rv_cnt == 0) begin
            flip = corrupt_all || (corrupt_en && rv_addr == corrupt_addr);
            bus.rvalid = 1'b1;
            bus.rdata  = mem[rv_addr] ^ {{(DATA_W-1){1'b0}}, flip};
          end
        end
        if (bus.req) begin
          if (ack_wait < 0) ack_wait = ack_hold ? 0 : int'($urandom_range(0, 3));
          if (ack_wait == 0) begin
            ack_wait = -1;
            bus.ack  = 1'b1;
            if (bus.we) begin
              mem[bus.addr[3:0]] = bus.wdata;
              wlog.push_back(bus.wdata);
              wcyc.push_back(cyc);
              if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("sb_wr", {bus.addr, bus.wdata}, e);
              end
            end else begin
              check_eq("rd_order", bus.addr, {20'b0, rd_next});
              rd_next = rd_next + 4'd1;
              rd_last = int'(bus.addr);
              rv_addr = bus.addr[3:0];
              rv_cnt  = 2;
            end
          end else begin
            ack_wait--;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
  endtask

  task automatic pulse_both();
    @(posedge clk); #1 begin start = 1'b1; stop = 1'b1; end
    @(posedge clk); #1 begin start = 1'b0; stop = 1'b0; end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < budget);
    check_eq(tag, busy, 0);
  endtask

  task automatic wait_pass(input string tag, input logic [3:0] v, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (pass_cnt != v && n < budget);
    check_eq(tag, pass_cnt, v);
  endtask

  task automatic wait_error(input string tag, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (!error && n < budget);
    check_eq(tag, error, 1);
  endtask

  task automatic wait_sb(input string tag, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (exp_q.size() != 0 && n < budget);
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic wait_cmd(input string tag, input logic w, input logic [ADDR_W-1:0] a, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(bus.req && bus.we == w && bus.addr == a) && n < budget);
    check_eq(tag, {bus.req, bus.we, bus.addr}, {1'b1, w, a});
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req"}, bus.req, 0);
    check_eq({tag, "_we"}, bus.we, 0);
    check_eq({tag, "_addr"}, bus.addr, 0);
    check_eq({tag, "_wdata"}, bus.wdata, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_error"}, error, 0);
    check_eq({tag, "_err_addr"}, err_addr, 0);
    check_eq({tag, "_err_cnt"}, err_cnt, 0);
    check_eq({tag, "_pass_cnt"}, pass_cnt, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    rst = 1'b0;

    // basic pass and second-pass seed
    wlog.delete(); wcyc.delete();
    fill_pass(4'd0); fill_pass(4'd1);
    pulse_start();
    check_eq("busy_rise", busy, 1);
    wait_pass("t1_pass1", 4'd1, 3000);
    check_eq("t1_err", error, 0);
    pulse_start();
    @(negedge clk);
    check_eq("t1_start_ign", pass_cnt, 1);
    wait_sb("t1_sb", 3000);
    pulse_stop();
    wait_idle("t1_idle", 3000);
    check_eq("t1_pass2", pass_cnt, 2);
    check_eq("t1_wcount", wlog.size(), 32);
    if (wlog.size() == 32) begin
      check_eq("t1_w0", wlog[0], 16'h2024);
      check_eq("t1_w1", wlog[1], 16'h9012);
      check_eq("t1_w2", wlog[2], 16'h4809);
      check_eq("t1_w3", wlog[3], 16'h2407);
      check_eq("t1_w16", wlog[16], 16'h2025);
    end

    // corrupt data at addr 5
    corrupt_en = 1; corrupt_addr = 4'd5;
    pulse_start();
    wait_error("t2_err", 3000);
    check_eq("t2_err_addr", err_addr, 5);
    check_eq("t2_err_cnt", err_cnt, 1);
`ifdef MEMTEST_ERR_HALT_EN
    repeat (4) @(negedge clk);
    check_eq("t2_halt_req", bus.req, 0);
    check_eq("t2_halt_busy", busy, 1);
    check_eq("t2_halt_state", dbg_state, ST_HALT);
    check_eq("t2_halt_cnt", err_cnt, 1);
    pulse_stop();
    wait_idle("t2_idle", 100);
`else
    wait_pass("t2_pass1", 4'd1, 3000);
    check_eq("t2_rd_last", rd_last, 15);
    check_eq("t2_cnt1", err_cnt, 1);
    pulse_stop();
    wait_idle("t2_idle", 3000);
    check_eq("t2_cnt2", err_cnt, 2);
    check_eq("t2_addr_sticky", err_addr, 5);
    check_eq("t2_pass2", pass_cnt, 2);
`endif
    corrupt_en = 0;

    // stop during the write phase
    pulse_start();
    wait_cmd("t3_w7", 1'b1, 24'd7, 2000);
    pulse_stop();
    wait_idle("t3_idle", 3000);
    check_eq("t3_pass", pass_cnt, 1);
    check_eq("t3_err", error, 0);
    check_eq("t3_rd_last", rd_last, 15);
    check_eq("t3_state", dbg_state, ST_IDLE);

    // ack held high: back-to-back writes
    ack_hold = 1;
    wlog.delete(); wcyc.delete();
    fill_pass(4'd0);
    pulse_start();
    pulse_stop();
    wait_idle("t4_idle", 1000);
    ack_hold = 0;
    check_eq("t4_sb", exp_q.size(), 0);
    check_eq("t4_wcount", wlog.size(), 16);
    if (wcyc.size() == 16) check_eq("t4_span", wcyc[15] - wcyc[0], 15);
    check_eq("t4_pass", pass_cnt, 1);

    // start+stop together, then reset mid-read
    pulse_both();
    wait_pass("t5_pass1", 4'd1, 3000);
    repeat (2) @(negedge clk);
    check_eq("t5_stop_drop", busy, 1);
    wait_cmd("t5_r9", 1'b0, 24'd9, 3000);
    rst = 1'b1;
    #1;
    check_all_zero("t5_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wlog.delete(); wcyc.delete();
    fill_pass(4'd0);
    pulse_start();
    wait_sb("t5_sb", 3000);
    if (wlog.size() > 0) check_eq("t5_w0", wlog[0], 16'h2024);
    pulse_stop();
    wait_idle("t5_idle", 3000);
    check_eq("t5_pass", pass_cnt, 1);

`ifndef MEMTEST_ERR_HALT_EN
    // every read corrupted: err_cnt saturates, pass_cnt wraps
    corrupt_all = 1;
    pulse_start();
    wait_pass("t6_p15", 4'd15, 5000);
    wait_pass("t6_wrap", 4'd0, 1000);
    check_eq("t6_sat", err_cnt, 255);
    check_eq("t6_err", error, 1);
    check_eq("t6_err_addr", err_addr, 0);
    pulse_stop();
    wait_idle("t6_idle", 1000);
    check_eq("t6_hold", err_cnt, 255);
    check_eq("t6_pass", pass_cnt, 1);
    corrupt_all = 0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
